booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
- Iterative sequencer for the radix-4 Booth significand multiplier.
- Instead of unrolling six Booth stages combinationally, it reuses one Booth step over six cycles, under a valid/ready handshake on both input and output.
- Sits between the FP unpack stage and the normalize/round stage of the half-precision multiply path. It trades latency for area.

Parameters:
- FRAC_W, 10: stored significand width; the hidden bit is added externally. The step count STEPS = (FRAC_W+2)/2 = 6 is a derived localparam.
- EARLY_ZERO, 1: when 1, a zero significand bypasses the Booth steps.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept operands.
- in_a  in  FRAC_W  multiplicand fraction.
- in_b  in  FRAC_W  multiplier fraction.
- in_azero  in  1  multiplicand hidden bit.
- in_bzero  in  1  multiplier hidden bit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- s  out  2*FRAC_W+4  product, zero-extended.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, step counter=0, accumulator=0, s=0, out_valid=0, busy=0. in_ready=1 once RST is deasserted.
- Reset mid-operation aborts the operation immediately; the partial result is discarded and never presented.
- Operands: M = {in_azero,in_a} and Q = {in_bzero,in_b}, both unsigned, 11 bits. Required result: s = {2'b0, M*Q}; the product is 22 bits and s[23:22] is always 0.
- Internal registers:
  - multiplicand +M and -M (two's complement), 13 bits, shifted up by 12.
  - accumulator P, 25 bits signed. Loaded as {12'b0, 1'b0, Q, 1'b0}, i.e. bit 0 is the implied Booth zero.
- States:
  - IDLE: in_ready=1. On in_valid, capture the operands.
    - If EARLY_ZERO and (M==0 or Q==0): go to DONE with s=0 (out_valid at T+1).
    - Otherwise go to STEP with cnt=0.
  - STEP: each cycle P <= step(P); cnt++. After cnt==STEPS-1, go to DONE and load s <= P[24:1].
  - DONE: out_valid=1, s held stable. When out_ready=1, go to IDLE. in_ready=0 in this state.
- Handshake rules:
  - in_ready=1 only in IDLE.
  - in_valid is ignored in every other state.
  - Operands only need to be valid in the accept cycle.
- Latency: accept at edge T; out_valid rises after edge T+7 (six STEP cycles plus the DONE transition). Minimum issue interval is 8 cycles, 9 if the consumer stalls.
- Booth step (C = P[2:0]):
  - 000 / 111: +0
  - 001 / 010: +M
  - 011: +2M
  - 100: −2M
  - 101 / 110: −M
  - The addend is aligned at P[24:12]; sum = {P[24],P[24:1]} + addend, then P_next = {sum[24],sum[24:1]}. This gives a net arithmetic shift of 2 per step.
- Output stability:
  - out_valid stays high until the handshake.
  - s changes only on entry to DONE. After the handshake, s retains its last value.
  - Backpressure of unbounded length is legal.
- Simultaneous events: out_ready high on the same cycle DONE is entered has no effect; the earliest handshake is one cycle later.
- Boundaries:
  - Maximum operands (2047*2047) must not overflow P; 25 bits cover the 13-bit 2M plus sign.
  - Q with top bit set needs no final correction, because the multiplier is zero-extended to 12 bits.

Decomposition:
- Shared package fp16_mul_pkg holds:
  - FRAC_W and SIG_W = FRAC_W+1.
  - Booth digit localparams: ZERO, PM1, PM2, NM1, NM2.
  - FSM state encoding: IDLE, STEP, DONE.
- One combinational sub-module, booth_r4_step. Inputs: P, +M, −M. Output: P_next. It is instantiated once; the FSM and counter live in booth_seq_ctrl.

Test Plan:
- azero=1,a=0, bzero=1,b=0 → s=0x100000 (1024*1024); out_valid exactly 7 cycles after accept.
- azero=1,a=0x3FF, bzero=1,b=0x3FF → s=0x3FF001 (2047*2047); no overflow.
- azero=1,a=0x200 (1536), bzero=1,b=0x100 (1280) → s=0x1E0000.
- azero=0,a=0, any b, EARLY_ZERO=1 → out_valid at T+1, s=0.
  - Same stimulus with EARLY_ZERO=0 → out_valid at T+7, s=0.
- Result pending, out_ready held low 5 cycles → out_valid stays 1, s stable, in_ready=0, and an in_valid pulse is ignored. Release out_ready → IDLE next cycle, next operands accepted.
- RST pulsed low during STEP with cnt=3 → out_valid=0, s=0, busy=0 asynchronously. A subsequent 1536*1280 returns 0x1E0000.
- Additionally, 2000 random operand pairs with random in_valid/out_ready gaps are checked against a behavioural integer product; busy is cross-checked against state.

Source files
------------

// File: rtl/fp16_mul_pkg.sv
// Shared types for the half-precision multiply path: widths, radix-4 Booth digits, sequencer states.
package fp16_mul_pkg;

    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 1;

    localparam logic [2:0] ZERO = 3'd0;
    localparam logic [2:0] PM1  = 3'd1;
    localparam logic [2:0] PM2  = 3'd2;
    localparam logic [2:0] NM1  = 3'd3;
    localparam logic [2:0] NM2  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Recode the overlapping multiplier triplet {q[i+1], q[i], q[i-1]} into a Booth digit.
    function automatic logic [2:0] booth_digit(input logic [2:0] c);
        logic [2:0] d;
        case (c)
            3'b001, 3'b010: d = PM1;
            3'b011:         d = PM2;
            3'b100:         d = NM2;
            3'b101, 3'b110: d = NM1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: add the recoded multiple of M at the top of P, net arithmetic shift of 2.
// Purely combinational; the caller registers P.
module booth_r4_step
    import fp16_mul_pkg::*;
#(
    parameter int FRAC_W = fp16_mul_pkg::FRAC_W,
    localparam int P_W   = 2 * FRAC_W + 5,
    localparam int A_W   = FRAC_W + 3
) (
    input  logic [P_W-1:0] p,
    input  logic [A_W-1:0] m_pos,
    input  logic [A_W-1:0] m_neg,
    output logic [P_W-1:0] p_next
);

    logic [A_W-1:0] addend;
    logic [P_W-1:0] sum;

    // Pre-shifting P by one keeps the 13-bit +-2M inside 25 bits without overflow.
    always_comb begin
        addend = '0;
        case (booth_digit(p[2:0]))
            PM1:     addend = m_pos;
            PM2:     addend = {m_pos[A_W-2:0], 1'b0};
            NM1:     addend = m_neg;
            NM2:     addend = {m_neg[A_W-2:0], 1'b0};
            default: addend = '0;
        endcase
        sum    = {p[P_W-1], p[P_W-1:1]} + {addend, {(P_W-A_W){1'b0}}};
        p_next = {sum[P_W-1], sum[P_W-1:1]};
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth significand multiplier: one shared step reused over STEPS cycles.
// Latency 7 cycles accept-to-out_valid (1 for a zero operand when EARLY_ZERO); result held until out_ready.
module booth_seq_ctrl
    import fp16_mul_pkg::*;
#(
    parameter int FRAC_W     = fp16_mul_pkg::FRAC_W,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAC_W-1:0]     in_a,
    input  logic [FRAC_W-1:0]     in_b,
    input  logic                  in_azero,
    input  logic                  in_bzero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*FRAC_W+3:0]   s,
    output logic                  busy
);

    localparam int SW    = FRAC_W + 1;
    localparam int P_W   = 2 * FRAC_W + 5;
    localparam int A_W   = FRAC_W + 3;
    localparam int STEPS = (FRAC_W + 2) / 2;
    localparam int CNT_W = $clog2(STEPS + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   p_next;
    logic [A_W-1:0]   m_pos;
    logic [A_W-1:0]   m_neg;
    logic [SW-1:0]    op_m;
    logic [SW-1:0]    op_q;
    logic             op_zero;

    assign op_m    = {in_azero, in_a};
    assign op_q    = {in_bzero, in_b};
    assign op_zero = EARLY_ZERO && ((op_m == '0) || (op_q == '0));

    booth_r4_step #(.FRAC_W(FRAC_W)) u_step (
        .p      (p),
        .m_pos  (m_pos),
        .m_neg  (m_neg),
        .p_next (p_next)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            p         <= '0;
            m_pos     <= '0;
            m_neg     <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_pos    <= {2'b00, op_m};
                        m_neg    <= '0 - {2'b00, op_m};
                        // Multiplier zero-extended to an even width so no final correction is needed.
                        p        <= {{(P_W-SW-1){1'b0}}, op_q, 1'b0};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (op_zero) begin
                            state     <= DONE;
                            s         <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state     <= DONE;
                        s         <= p_next[P_W-1:1];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomised self-checking bench for booth_seq_ctrl against an integer-product / cycle-count model.
module tb_booth_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0, in_valid0 = 1'b0;
    logic        out_ready = 1'b0, out_ready0 = 1'b0;
    logic [9:0]  in_a = '0, in_b = '0;
    logic        in_azero = 1'b0, in_bzero = 1'b0;
    logic        in_ready, in_ready0, out_valid, out_valid0, busy, busy0;
    logic [23:0] s, s0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    booth_seq_ctrl #(.FRAC_W(10), .EARLY_ZERO(1'b1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_azero(in_azero), .in_bzero(in_bzero),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .busy(busy)
    );

    booth_seq_ctrl #(.FRAC_W(10), .EARLY_ZERO(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_azero(in_azero), .in_bzero(in_bzero),
        .out_valid(out_valid0), .out_ready(out_ready0), .s(s0), .busy(busy0)
    );

    function automatic logic get_ov(input bit sel);
        return sel ? out_valid0 : out_valid;
    endfunction
    function automatic logic get_ir(input bit sel);
        return sel ? in_ready0 : in_ready;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy0 : busy;
    endfunction
    function automatic logic [23:0] get_s(input bit sel);
        return sel ? s0 : s;
    endfunction

    task automatic scramble();
        in_a     = 10'($urandom_range(0, 1023));
        in_b     = 10'($urandom_range(0, 1023));
        in_azero = 1'($urandom_range(0, 1));
        in_bzero = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input bit sel, input logic az, input logic [9:0] a,
                         input logic bz, input logic [9:0] b);
        @(negedge CLK);
        checks++;
        if (get_ir(sel) !== 1'b1) begin
            errors++;
            $display("FAIL issue_in_ready sel=%0d got=%b want=1", sel, get_ir(sel));
        end
        in_azero = az; in_a = a; in_bzero = bz; in_b = b;
        if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0; in_valid0 = 1'b0;
        scramble();
    endtask

    task automatic wait_result(input bit sel, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            lat++;
            if (get_ov(sel) === 1'b1) break;
        end
    endtask

    task automatic handshake(input bit sel);
        if (sel) out_ready0 = 1'b1; else out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0; out_ready0 = 1'b0;
        @(negedge CLK);
        checks++;
        if (get_ov(sel) !== 1'b0 || get_ir(sel) !== 1'b1 || get_busy(sel) !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake sel=%0d got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0",
                     sel, get_ov(sel), get_ir(sel), get_busy(sel));
        end
    endtask

    task automatic run_op(input bit sel, input logic az, input logic [9:0] a,
                          input logic bz, input logic [9:0] b, input string name,
                          output logic [23:0] got);
        int m, q, lat, exp_lat;
        logic [23:0] exp_s;
        m = int'({az, a});
        q = int'({bz, b});
        exp_s   = 24'(m * q);
        exp_lat = (!sel && (m == 0 || q == 0)) ? 1 : 7;
        issue(sel, az, a, bz, b);
        wait_result(sel, lat);
        got = get_s(sel);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
        end
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL %s_product got=%h want=%h", name, got, exp_s);
        end
        handshake(sel);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || s !== 24'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b s=%h busy=%b want ov=0 s=0 busy=0", out_valid, s, busy);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b/%b want=1/1", in_ready, in_ready0);
        end
    endtask

    task automatic test_products();
        logic [23:0] got;
        run_op(1'b0, 1'b1, 10'h000, 1'b1, 10'h000, "p1024x1024", got);
        checks++;
        if (got !== 24'h100000) begin errors++; $display("FAIL const_1024 got=%h want=100000", got); end
        run_op(1'b0, 1'b1, 10'h3FF, 1'b1, 10'h3FF, "p2047x2047", got);
        checks++;
        if (got !== 24'h3FF001) begin errors++; $display("FAIL const_2047 got=%h want=3ff001", got); end
        run_op(1'b0, 1'b1, 10'h200, 1'b1, 10'h100, "p1536x1280", got);
        checks++;
        if (got !== 24'h1E0000) begin errors++; $display("FAIL const_1536 got=%h want=1e0000", got); end
    endtask

    task automatic test_early_zero();
        logic [23:0] got;
        logic [9:0]  rb;
        rb = 10'($urandom_range(1, 1023));
        run_op(1'b0, 1'b0, 10'h000, 1'b1, rb, "ez_a0", got);
        run_op(1'b0, 1'b1, rb, 1'b0, 10'h000, "ez_b0", got);
        run_op(1'b1, 1'b0, 10'h000, 1'b1, rb, "noez_a0", got);
        run_op(1'b1, 1'b1, 10'h155, 1'b1, 10'h0AA, "noez_mixed", got);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [23:0] got;
        issue(1'b0, 1'b1, 10'h200, 1'b1, 10'h100);
        wait_result(1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; in_azero = 1'b1; in_a = 10'h3FF; in_bzero = 1'b1; in_b = 10'h3FF;
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if (out_valid !== 1'b1 || s !== 24'h1E0000 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d got ov=%b s=%h ir=%b busy=%b want ov=1 s=1e0000 ir=0 busy=1",
                         i, out_valid, s, in_ready, busy);
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || s !== 24'h1E0000) begin
            errors++;
            $display("FAIL stall_end got ov=%b s=%h want ov=1 s=1e0000", out_valid, s);
        end
        handshake(1'b0);
        checks++;
        if (s !== 24'h1E0000) begin
            errors++;
            $display("FAIL s_retained got=%h want=1e0000", s);
        end
        run_op(1'b0, 1'b0, 10'h3A5, 1'b1, 10'h05A, "after_stall", got);
    endtask

    task automatic test_reset_mid();
        logic [23:0] got;
        issue(1'b0, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_op_busy got busy=%b ov=%b want busy=1 ov=0", busy, out_valid);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || s !== 24'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got ov=%b s=%h busy=%b want ov=0 s=0 busy=0", out_valid, s, busy);
        end
        #2;
        RST = 1'b1;
        run_op(1'b0, 1'b1, 10'h200, 1'b1, 10'h100, "post_reset", got);
        checks++;
        if (got !== 24'h1E0000) begin errors++; $display("FAIL post_reset_const got=%h want=1e0000", got); end
    endtask

    task automatic test_random();
        int cyc = 0, ops = 0, acc_k = 0, exp_lat = 0, nxt_lat = 0, m, q, r;
        bit pend = 0, acc_dec = 0, hs_dec = 0, have_last = 0, exp_ov;
        logic [23:0] exp_s = '0, last_s = '0, nxt_s = '0;
        while (ops < 2000 && cyc < 60000) begin
            @(negedge CLK);
            cyc++;
            if (hs_dec) begin pend = 0; ops++; last_s = exp_s; have_last = 1; end
            if (acc_dec) begin pend = 1; acc_k = cyc - 1; exp_s = nxt_s; exp_lat = nxt_lat; end
            exp_ov = pend && (cyc >= acc_k + exp_lat);
            checks++;
            if (busy !== pend) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, pend); end
            checks++;
            if (in_ready !== !pend) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !pend); end
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++;
                if (s !== exp_s) begin errors++; $display("FAIL rnd_product cyc=%0d got=%h want=%h", cyc, s, exp_s); end
            end else if (have_last) begin
                checks++;
                if (s !== last_s) begin errors++; $display("FAIL rnd_s_hold cyc=%0d got=%h want=%h", cyc, s, last_s); end
            end
            in_valid = ($urandom_range(0, 2) == 0);
            scramble();
            r = int'($urandom_range(0, 7));
            if (r == 0) begin in_azero = 1'b0; in_a = '0; end
            if (r == 1) begin in_bzero = 1'b0; in_b = '0; end
            m = int'({in_azero, in_a});
            q = int'({in_bzero, in_b});
            nxt_s   = 24'(m * q);
            nxt_lat = (m == 0 || q == 0) ? 1 : 7;
            out_ready = 1'($urandom_range(0, 1));
            acc_dec = in_valid && !pend;
            hs_dec  = out_ready && exp_ov;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (ops < 2000) begin
            errors++;
            $display("FAIL rnd_timeout got=%0d ops want=2000", ops);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_products();
        test_early_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
